// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: per-bit edge/bit timebase and 3-sample majority-vote bit sampler for the UART RX FSM
module uart_rx_oversampler #(
  parameter int EDGE_W = 5,
  parameter int BIT_W  = 4
) (
  input  logic              clk_RX,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic [5:0]        prescale,
  input  logic              PAR_EN,
  input  logic              edge_cnt_enable,
  input  logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              edge_cnt_max,
  output logic              take_sample,
  output logic              sampled_bit
);
  logic [5:0]       p;
  logic [2:0]       s;
  logic [5:0]       ec;
  logic [5:0]       m;
  logic             wrap;
  logic             samp;
  logic             legal;
  logic             maj;
  logic [BIT_W-1:0] last;
  assign ec           = 6'(edge_cnt);
  assign m            = {1'b0, p[5:1]};
  assign wrap         = ec == p - 6'd1;
  assign samp         = dat_samp_en & edge_cnt_enable;
  assign legal        = prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32;
  assign maj          = (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
  assign last         = PAR_EN ? BIT_W'(10) : BIT_W'(9);
  assign edge_cnt_max = edge_cnt_enable & wrap;
  always_ff @(posedge clk_RX) begin
    if (!rst) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      take_sample <= 1'b0;
      sampled_bit <= 1'b1;
      s           <= '0;
      p           <= 6'd8;
    end else begin
      if (!edge_cnt_enable) p <= legal ? prescale : 6'd8;
      edge_cnt    <= (!edge_cnt_enable || wrap) ? '0 : edge_cnt + EDGE_W'(1);
      bit_cnt     <= !edge_cnt_enable ? '0 : !wrap ? bit_cnt : (bit_cnt >= last ? '0 : bit_cnt + BIT_W'(1));
      take_sample <= samp && ec == m + 6'd1;
      // sample window straddles mid-bit: M-2, M-1, M
      s[0]        <= !samp ? 1'b0 : ec == m - 6'd2 ? RX_IN : s[0];
      s[1]        <= !samp ? 1'b0 : ec == m - 6'd1 ? RX_IN : s[1];
      s[2]        <= !samp ? 1'b0 : ec == m        ? RX_IN : s[2];
      if (samp && ec == m + 6'd1) sampled_bit <= maj;
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: directed frames with a queue of expected majority bits popped on each take_sample
module tb_uart_rx_oversampler;
  logic       clk_RX = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       edge_cnt_enable = 1'b0;
  logic       dat_samp_en = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       edge_cnt_max;
  logic       take_sample;
  logic       sampled_bit;
  int errors = 0;
  int checks = 0;
  int cur_p = 8;
  bit exp_q[$];

  uart_rx_oversampler dut (
    .clk_RX(clk_RX), .rst(rst), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
    .edge_cnt_enable(edge_cnt_enable), .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .edge_cnt_max(edge_cnt_max), .take_sample(take_sample), .sampled_bit(sampled_bit)
  );

  always #5 clk_RX = ~clk_RX;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_RX);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one bit period of ne edges, optionally inverting RX_IN on edges glo..ghi
  task automatic run_bit(input bit v, input int bi, input int ne, input int glo, input int ghi,
                         input bit push, input bit exp);
    for (int e = 0; e < ne; e++) begin
      RX_IN = (e >= glo && e <= ghi) ? ~v : v;
      if (e == 0 && push) exp_q.push_back(exp);
      chk("edge_cnt", edge_cnt, e);
      chk("bit_cnt", bit_cnt, bi);
      chk("edge_cnt_max", edge_cnt_max, e == cur_p - 1);
      step();
    end
  endtask

  task automatic idle_latch(input logic [5:0] ps, input int p);
    edge_cnt_enable = 1'b0;
    prescale = ps;
    step();
    cur_p = p;
    edge_cnt_enable = 1'b1;
    dat_samp_en = 1'b1;
  endtask

  always @(negedge clk_RX) begin
    if (take_sample === 1'b1) begin
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        bit e;
        e = exp_q.pop_front();
        chk("sampled_bit", sampled_bit, e);
        chk("take_sample_edge", edge_cnt, cur_p / 2 + 2);
      end
    end
  end

  initial begin
    step(2);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_edge_cnt_max", edge_cnt_max, 0);
    chk("rst_take_sample", take_sample, 0);
    chk("rst_sampled_bit", sampled_bit, 1);
    rst = 1'b1;
    step();
    // frame 0x55, P=8, no parity
    PAR_EN = 1'b0;
    idle_latch(6'd8, 8);
    for (int b = 0; b < 10; b++) run_bit(1'(b % 2), b, 8, -1, -1, 1'b1, 1'(b % 2));
    chk("t1_bit_wrap", bit_cnt, 0);
    chk("t1_edge_wrap", edge_cnt, 0);
    // P=16 with parity: 11 bits
    PAR_EN = 1'b1;
    idle_latch(6'd16, 16);
    for (int b = 0; b < 11; b++) run_bit(b % 3 != 0, b, 16, -1, -1, 1'b1, b % 3 != 0);
    chk("t2_bit_wrap", bit_cnt, 0);
    // glitch rejection at P=16 (samples at 6,7,8)
    idle_latch(6'd16, 16);
    run_bit(1'b1, 0, 16, 6, 7, 1'b1, 1'b0);
    run_bit(1'b1, 1, 16, 7, 7, 1'b1, 1'b1);
    // prescale change mid-frame ignored
    idle_latch(6'd16, 16);
    run_bit(1'b0, 0, 16, -1, -1, 1'b1, 1'b0);
    prescale = 6'd32;
    run_bit(1'b1, 1, 16, -1, -1, 1'b1, 1'b1);
    run_bit(1'b0, 2, 16, -1, -1, 1'b1, 1'b0);
    idle_latch(6'd32, 32);
    run_bit(1'b0, 0, 32, -1, -1, 1'b1, 1'b0);
    run_bit(1'b1, 1, 32, -1, -1, 1'b1, 1'b1);
    idle_latch(6'd12, 8);
    run_bit(1'b0, 0, 8, -1, -1, 1'b1, 1'b0);
    run_bit(1'b1, 1, 8, -1, -1, 1'b1, 1'b1);
    // enable dropped at edge 9 of bit 4, coinciding with the would-be vote
    idle_latch(6'd16, 16);
    for (int b = 0; b < 4; b++) run_bit(1'(b % 2), b, 16, -1, -1, 1'b1, 1'(b % 2));
    run_bit(1'b0, 4, 9, -1, -1, 1'b0, 1'b0);
    chk("t5_edge_before", edge_cnt, 9);
    edge_cnt_enable = 1'b0;
    step();
    chk("t5_edge_cnt", edge_cnt, 0);
    chk("t5_bit_cnt", bit_cnt, 0);
    chk("t5_take_sample", take_sample, 0);
    chk("t5_edge_cnt_max", edge_cnt_max, 0);
    step(3);
    chk("t5_sampled_hold", sampled_bit, 1);
    // reset mid-frame at bit 5
    idle_latch(6'd8, 8);
    for (int b = 0; b < 5; b++) run_bit(b == 4 ? 1'b0 : 1'(b % 2), b, 8, -1, -1, 1'b1, b == 4 ? 1'b0 : 1'(b % 2));
    run_bit(1'b1, 5, 4, -1, -1, 1'b0, 1'b0);
    chk("t6_sampled_pre", sampled_bit, 0);
    rst = 1'b0;
    step();
    chk("t6_edge_cnt", edge_cnt, 0);
    chk("t6_bit_cnt", bit_cnt, 0);
    chk("t6_edge_cnt_max", edge_cnt_max, 0);
    chk("t6_take_sample", take_sample, 0);
    chk("t6_sampled_bit", sampled_bit, 1);
    step(2);
    chk("t6_held_in_rst", edge_cnt, 0);
    rst = 1'b1;
    edge_cnt_enable = 1'b0;
    step();
    chk("t6_idle_after_rst", edge_cnt, 0);
    edge_cnt_enable = 1'b1;
    step();
    chk("t6_restart", edge_cnt, 1);
    edge_cnt_enable = 1'b0;
    dat_samp_en = 1'b0;
    step(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
